// File: rtl/tl_beat_tracker.sv
// Burst sequencer for a TileLink A/C-style channel: decodes the first beat's opcode/size into a
// beat count and drives a zero-latency last flag so multi-beat messages are never interleaved.
module tl_beat_tracker #(
  parameter int unsigned         DATA_BYTES = 8,
  parameter int unsigned         OP_W       = 3,
  parameter int unsigned         SIZE_W     = 4,
  parameter int unsigned         MAX_SIZE   = 6,
  parameter logic [2**OP_W-1:0]  DATA_OPS   = 8'b0000_0111,
  localparam int unsigned        LOG2_BYTES = $clog2(DATA_BYTES),
  localparam int unsigned        CNT_W      = (MAX_SIZE > LOG2_BYTES) ? MAX_SIZE - LOG2_BYTES : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              ready_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [SIZE_W-1:0] size_i,
  output logic              last_o,
  output logic              first_o,
  output logic [CNT_W-1:0]  beat_idx_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [SIZE_W-1:0] MaxSize   = SIZE_W'(MAX_SIZE);
  localparam logic [SIZE_W-1:0] Log2Bytes = SIZE_W'(LOG2_BYTES);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  total_q;
  logic [OP_W-1:0]   op_q;
  logic [SIZE_W-1:0] size_q;
  logic              err_q;

  logic              fire;
  logic              oversize;
  logic [SIZE_W-1:0] size_clamped;
  logic [SIZE_W-1:0] shift;
  logic [CNT_W:0]    beats;
  logic [CNT_W-1:0]  hdr_total;
  logic              hdr_single;

  assign fire     = valid_i & ready_i;
  assign oversize = size_i > MaxSize;

  // Header decode of the live beat; only meaningful while idle.
  always_comb begin
    size_clamped = oversize ? MaxSize : size_i;
    shift        = '0;
    if (DATA_OPS[opcode_i] && (size_clamped > Log2Bytes)) begin
      shift = size_clamped - Log2Bytes;
    end
    beats      = (CNT_W + 1)'(1) << shift;
    hdr_total  = CNT_W'(beats - (CNT_W + 1)'(1));
    hdr_single = (hdr_total == '0);
  end

  assign first_o    = ~busy_q;
  assign beat_idx_o = busy_q ? cnt_q : '0;
  assign last_o     = busy_q ? (cnt_q == total_q) : hdr_single;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      total_q <= '0;
      op_q    <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else if (fire) begin
      if (oversize) begin
        err_q <= 1'b1;
      end
      if (busy_q) begin
        // A changed header mid-burst is flagged but the latched length still governs.
        if ((opcode_i != op_q) || (size_i != size_q)) begin
          err_q <= 1'b1;
        end
        if (cnt_q == total_q) begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (!hdr_single) begin
        busy_q  <= 1'b1;
        cnt_q   <= CNT_W'(1);
        total_q <= hdr_total;
        op_q    <= opcode_i;
        size_q  <= size_i;
      end
    end
  end

endmodule

// File: tb/tb_tl_beat_tracker.sv
// Self-checking bench for tl_beat_tracker: table of per-cycle vectors run through a scoreboard
// queue, plus a randomly stalled burst checked against a beat counter.
module tb_tl_beat_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [2:0] opcode;
  logic [3:0] size;
  logic       last;
  logic       first;
  logic [2:0] beat_idx;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  tl_beat_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid),
    .ready_i    (ready),
    .opcode_i   (opcode),
    .size_i     (size),
    .last_o     (last),
    .first_o    (first),
    .beat_idx_o (beat_idx),
    .busy_o     (busy),
    .err_o      (err)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic       ready;
    logic [2:0] op;
    logic [3:0] sz;
    logic       last;
    logic       first;
    logic [2:0] idx;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic rd, input int op,
                              input int sz, input logic l, input logic f, input int idx,
                              input logic b, input logic e);
    vec_t x;
    x.rst = r; x.valid = v; x.ready = rd; x.op = 3'(op); x.sz = 4'(sz);
    x.last = l; x.first = f; x.idx = 3'(idx); x.busy = b; x.err = e;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected record is queued when driven and popped when the outputs are sampled.
  task automatic apply(input vec_t v, input int row);
    vec_t e;
    @(negedge clk);
    rst = v.rst; valid = v.valid; ready = v.ready; opcode = v.op; size = v.sz;
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    check($sformatf("row%0d last", row), int'(last), int'(e.last));
    check($sformatf("row%0d first", row), int'(first), int'(e.first));
    check($sformatf("row%0d idx", row), int'(beat_idx), int'(e.idx));
    check($sformatf("row%0d busy", row), int'(busy), int'(e.busy));
    check($sformatf("row%0d err", row), int'(err), int'(e.err));
  endtask

  task automatic random_stall_burst();
    int beat = 0;
    int cycles = 0;
    while (beat < 8 && cycles < 200) begin
      @(negedge clk);
      rst = 1'b0; valid = 1'($urandom_range(0, 1)); ready = 1'($urandom_range(0, 1));
      opcode = 3'd2; size = 4'd6;
      #2;
      check($sformatf("rnd beat%0d idx", beat), int'(beat_idx), beat);
      check($sformatf("rnd beat%0d last", beat), int'(last), int'(beat == 7));
      check($sformatf("rnd beat%0d first", beat), int'(first), int'(beat == 0));
      if (valid && ready) beat++;
      cycles++;
    end
    if (beat < 8) begin
      n_tests++;
      n_fail++;
      $display("FAIL rnd timeout: got %0d beats expected 8", beat);
    end
    @(negedge clk);
    valid = 1'b0; ready = 1'b0;
    #2;
    check("rnd busy after", int'(busy), 0);
    check("rnd err after", int'(err), 0);
  endtask

  initial begin
    // Reset state with idle inputs
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    // 1: single-beat Get, busy stays low
    vecs.push_back(mk(0, 1, 1, 4, 6, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    // 2: full 8-beat burst
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(0, 1, 1, 0, 6, logic'(i == 7), logic'(i == 0), i, logic'(i > 0), 0));
    end
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    // 3: 2-beat burst with stalls, including ready without valid
    vecs.push_back(mk(0, 1, 1, 1, 4, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 1, 4, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 4, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    // Single-beat boundaries: size at beat width, and a non-data opcode
    vecs.push_back(mk(0, 1, 1, 0, 3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 3, 6, 1, 1, 0, 0, 0));
    // 4: header change mid-burst, burst still lasts 4 fires
    vecs.push_back(mk(0, 1, 1, 0, 5, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 5, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 3, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 5, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    // 5: oversize header clamps to 8 beats, then reset wins over a same-cycle fire
    vecs.push_back(mk(0, 1, 1, 0, 9, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 9, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 9, 0, 0, 2, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 9, 0, 0, 3, 1, 1));
    vecs.push_back(mk(0, 1, 1, 4, 0, 1, 1, 0, 0, 0));
    // 6: back-to-back 2-beat then 1-beat message
    vecs.push_back(mk(0, 1, 1, 1, 4, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 4, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 4, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

    rst = 1'b1; valid = 1'b0; ready = 1'b0; opcode = '0; size = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    random_stall_burst();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
